// File: rtl/elevator_scheduler_pkg.sv
// Shared definitions for the elevator scheduler: state encodings, floor
// geometry, the "no call" encoder code and small mask helpers.
package elevator_scheduler_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = 2;

    localparam logic [2:0] NO_REQ = 3'b100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_DOOR = 2'd2;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Floors strictly beyond 'floor' when travelling in direction 'up'.
    function automatic logic [NUM_FLOORS-1:0] beyond_mask(
        input logic [FLOOR_W-1:0] floor,
        input logic               up
    );
        logic [NUM_FLOORS-1:0] mask;
        mask = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            mask[f] = up ? (f > int'(floor)) : (f < int'(floor));
        end
        return mask;
    endfunction

    // Single-bit mask selecting one floor.
    function automatic logic [NUM_FLOORS-1:0] floor_onehot(
        input logic [FLOOR_W-1:0] floor
    );
        logic [NUM_FLOORS-1:0] mask;
        mask = '0;
        mask[floor] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/elevator_scheduler_cycle_timer.sv
// Loadable down-counter shared by the travel and door phases. A load
// presets the count; while enabled it decrements until it reaches zero,
// where it parks and raises done.
module cycle_timer
    import elevator_scheduler_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    assign done = (count == '0);

    // Load takes priority over counting; the counter never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && !done) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator controller for a 4-floor car. Latches floor calls, keeps
// travelling in the current direction while calls remain ahead, opens the
// door on each served floor and only reverses direction from IDLE.
module elevator_scheduler
    import elevator_scheduler_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            floor_req,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  dir;
    logic                  dir_next;
    logic [FLOOR_W-1:0]    floor_next;
    logic [FLOOR_W-1:0]    arrive_floor;
    logic [NUM_FLOORS-1:0] pending_next;
    logic [NUM_FLOORS-1:0] set_mask;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic                  req_valid;
    logic [FLOOR_W-1:0]    req_floor;
    logic                  timer_load;
    logic                  timer_en;
    logic [TW-1:0]         timer_value;
    logic                  timer_done;

    assign req_valid    = (floor_req < NO_REQ);
    assign req_floor    = floor_req[FLOOR_W-1:0];
    assign arrive_floor = (dir == DIR_UP) ? current_floor + 2'd1 : current_floor - 2'd1;

    cycle_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timer_load),
        .enable    (timer_en),
        .load_value(timer_value),
        .done      (timer_done)
    );

    // Next-state, direction, floor, timer control and pending-call update.
    always_comb begin
        state_next  = state;
        dir_next    = dir;
        floor_next  = current_floor;
        clear_mask  = '0;
        set_mask    = '0;
        timer_load  = 1'b0;
        timer_en    = 1'b0;
        timer_value = '0;

        case (state)
            ST_IDLE: begin
                if (pending[current_floor]) begin
                    state_next  = ST_DOOR;
                    clear_mask  = floor_onehot(current_floor);
                    timer_load  = 1'b1;
                    timer_value = DOOR_LOAD;
                end else if (|(pending & beyond_mask(current_floor, dir))) begin
                    state_next  = ST_MOVE;
                    timer_load  = 1'b1;
                    timer_value = TRAVEL_LOAD;
                end else if (|(pending & beyond_mask(current_floor, ~dir))) begin
                    state_next  = ST_MOVE;
                    dir_next    = ~dir;
                    timer_load  = 1'b1;
                    timer_value = TRAVEL_LOAD;
                end
            end
            ST_MOVE: begin
                if (timer_done) begin
                    floor_next = arrive_floor;
                    if (pending[arrive_floor]) begin
                        state_next  = ST_DOOR;
                        clear_mask  = floor_onehot(arrive_floor);
                        timer_load  = 1'b1;
                        timer_value = DOOR_LOAD;
                    end else if (|(pending & beyond_mask(arrive_floor, dir))) begin
                        timer_load  = 1'b1;
                        timer_value = TRAVEL_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_DOOR: begin
                if (req_valid && (req_floor == current_floor)) begin
                    timer_load  = 1'b1;
                    timer_value = DOOR_LOAD;
                end else if (timer_done) begin
                    state_next = ST_IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (req_valid && !((state == ST_DOOR) && (req_floor == current_floor))) begin
            set_mask = floor_onehot(req_floor);
        end

        pending_next = (pending | set_mask) & ~clear_mask;
    end

    // Registered state and outputs; motion and door flags follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            dir           <= DIR_UP;
            current_floor <= '0;
            pending       <= '0;
            moving_up     <= 1'b0;
            moving_down   <= 1'b0;
            door_open     <= 1'b0;
        end else begin
            state         <= state_next;
            dir           <= dir_next;
            current_floor <= floor_next;
            pending       <= pending_next;
            moving_up     <= (state_next == ST_MOVE) && (dir_next == DIR_UP);
            moving_down   <= (state_next == ST_MOVE) && (dir_next == DIR_DOWN);
            door_open     <= (state_next == ST_DOOR);
        end
    end

endmodule
